md_handover_ctrl: RTL and testbench
===================================

Name: md_handover_ctrl

Overview:
- Handover controller for the mobile device (MD) side.
- Selects the serving base station (BS1..BS3) from per-BS request and signal-quality (sq) inputs, and sequences a req/ack attach handshake with the chosen BS.
- Performs make-before-break handover with hysteresis and dwell filtering.
- Drives the 2-bit target code consumed by the MD/BS demux (0/1/2 = BS1/BS2/BS3, 3 = none).

Parameters:
- MIN_SQ, 1: minimum sq (0..3) for a BS to be usable.
- HYST, 1: sq margin a candidate must exceed the serving BS by.
- DWELL, 4: consecutive cycles the handover condition must hold (>=1).
- TIMEOUT, 8: max cycles to wait for ack (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- bs_request  in  3  bit i = BS(i+1) offers service.
- sq1, sq2, sq3  in  2 each  quality per BS; higher is better.
- bs_ack  in  3  bit i = BS(i+1) accepts attach/handover.
- target  out  2  serving BS code; 3 = none.
- ho_req  out  3  one-hot attach/handover request to candidate BS.
- attached  out  1  a BS is serving.
- ho_busy  out  1  handover handshake in progress.
- ho_count  out  8  completed handovers, saturating at 255.

Behaviour:
- Reset values: target=3, ho_req=0, attached=0, ho_busy=0, ho_count=0, state=IDLE, dwell/timeout counters=0. All outputs are registered.
- Usable BS i: bs_request[i]=1 and sq_i>=MIN_SQ.
- Best candidate: usable BS with highest sq. Ties go to the lowest index. In ATTACHED, the serving BS is excluded from candidacy.
- Comparisons: 3-bit arithmetic, so sq_serv+HYST never wraps. Condition is sq_cand >= sq_serv+HYST.
- States: IDLE, CONNECT, ATTACHED, HANDOVER.
- IDLE:
  - If a candidate exists: latch cand, ho_req[cand]<=1, go to CONNECT.
  - Otherwise stay; all outputs idle.
- CONNECT:
  - Timer starts at 0 on entry and increments each cycle.
  - bs_ack[cand]=1 → ho_req<=0, target<=cand, attached<=1, go to ATTACHED.
  - Else if timer==TIMEOUT-1 → ho_req<=0, go to IDLE.
  - Ack on the final timeout cycle wins over timeout.
  - Acks from non-candidate BSs are ignored.
- ATTACHED:
  - Link loss (serving BS not usable) takes priority: target<=3, attached<=0, dwell<=0, go to IDLE.
  - Otherwise, if the best candidate meets the hysteresis condition: increment dwell; dwell restarts at 1 if the candidate index changed from last cycle.
  - When the condition holds for DWELL consecutive cycles: latch cand, ho_req[cand]<=1, ho_busy<=1, dwell<=0, go to HANDOVER. With DWELL=1, the request is issued the cycle after the first qualifying sample.
  - If the condition fails: dwell<=0.
- HANDOVER (make-before-break):
  - target and attached stay at the old values throughout.
  - bs_ack[cand]=1 → target<=cand, ho_req<=0, ho_busy<=0, ho_count<=sat(ho_count+1), go to ATTACHED.
  - Timeout at TIMEOUT-1 → ho_req<=0, ho_busy<=0, go to ATTACHED with the old target.
  - Serving-link loss is not checked here. It is detected in ATTACHED on the following cycle.
- ho_req stays high continuously from the issue cycle until the cycle after ack or timeout. At most one bit is set.
- Reset asserted mid-handshake: next edge returns all state and outputs to reset values; ho_req drops immediately.

Test Plan:
- Initial attach: after reset, bs_request=3'b011, sq1=2, sq2=3 → ho_req=3'b010 the cycle after. bs_ack=3'b010 two cycles later → target=1, attached=1, ho_req=0, ho_count=0.
- Tie and timeout: bs_request=3'b101, sq1=sq3=2 → ho_req=3'b001. No ack for 8 cycles → ho_req=0 after cycle 8, state IDLE, then re-request BS1.
- Handover with dwell: attached to BS1 (sq1=1), raise sq2=3 with BS2 requesting → ho_req=3'b010 and ho_busy=1 after 4 cycles. target stays 0 until ack. Ack → target=1, ho_count=1.
- Hysteresis and dwell reset: serving sq=2, candidate sq=2 → no handover. Candidate sq=3 for 3 cycles, then 2, then 3 for 3 cycles → no ho_req.
- Link loss: attached to BS3, drop bs_request[2] → target=3 and attached=0 next cycle. If another BS is usable, the following cycle issues ho_req to it.
- Reset mid-HANDOVER and saturation:
  - reset=1 while ho_req=3'b100 → ho_req=0, target=3, ho_count=0 next cycle.
  - Drive 256 completed handovers → ho_count holds 255.

Source files
------------

// File: rtl/md_handover_ctrl.sv
// MD-side serving base station selector with req/ack attach and make-before-break handover.
// Latency: every output is registered; a request goes out the cycle after a qualifying candidate is sampled.
// Backpressure: none; the ack handshake is abandoned after TIMEOUT cycles and the controller falls back.
module md_handover_ctrl #(
  parameter int MIN_SQ  = 1,
  parameter int HYST    = 1,
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] bs_request,
  input  logic [1:0] sq1,
  input  logic [1:0] sq2,
  input  logic [1:0] sq3,
  input  logic [2:0] bs_ack,
  output logic [1:0] target,
  output logic [2:0] ho_req,
  output logic       attached,
  output logic       ho_busy,
  output logic [7:0] ho_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DMAX  = DW'(DWELL);
  localparam logic [2:0]    MIN3  = 3'(MIN_SQ);
  localparam logic [2:0]    HYST3 = 3'(HYST);
  localparam logic [1:0]    NONE  = 2'd3;

  typedef enum logic [1:0] {IDLE, CONNECT, ATTACHED, HANDOVER} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cand_q, cand_d;      // handshake target; in ATTACHED it remembers last cycle's candidate
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    target_q, target_d;
  logic [2:0]    ho_req_q, ho_req_d;
  logic          attached_q, attached_d;
  logic          ho_busy_q, ho_busy_d;
  logic [7:0]    ho_count_q, ho_count_d;

  logic [1:0]    sq [3];
  logic [2:0]    usable, elig, serv_oh, cand_oh;
  logic          cand_vld, serv_ok, ho_cond, ack_hit;
  logic [1:0]    cand_idx, cand_sq, serv_sq;
  logic [DW-1:0] dwell_n;

  assign sq[0] = sq1;
  assign sq[1] = sq2;
  assign sq[2] = sq3;

  // Candidate search: best usable BS by sq, lowest index on ties, serving BS excluded while attached
  always_comb begin
    serv_oh = 3'b000;
    serv_sq = 2'd0;
    case (target_q)
      2'd0:    begin serv_oh = 3'b001; serv_sq = sq[0]; end
      2'd1:    begin serv_oh = 3'b010; serv_sq = sq[1]; end
      2'd2:    begin serv_oh = 3'b100; serv_sq = sq[2]; end
      default: begin serv_oh = 3'b000; serv_sq = 2'd0;  end
    endcase
    for (int i = 0; i < 3; i++) begin
      usable[i] = bs_request[i] && ({1'b0, sq[i]} >= MIN3);
    end
    elig = usable;
    if (state_q == ATTACHED) elig = usable & ~serv_oh;
    cand_vld = 1'b0;
    cand_idx = 2'd0;
    cand_sq  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (!cand_vld || sq[i] > cand_sq)) begin
        cand_vld = 1'b1;
        cand_idx = 2'(i);
        cand_sq  = sq[i];
      end
    end
    cand_oh = 3'b001 << cand_idx;
    serv_ok = |(usable & serv_oh);
    ho_cond = cand_vld && ({1'b0, cand_sq} >= ({1'b0, serv_sq} + HYST3));
    // ho_req is one-hot on the latched candidate, so this ignores acks from other BSs
    ack_hit = |(bs_ack & ho_req_q);
    dwell_n = (dwell_q == '0 || cand_idx != cand_q) ? DW'(1) : dwell_q + DW'(1);
  end

  // Next-state and next-output computation for the attach / handover sequencer
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    timer_d    = timer_q;
    dwell_d    = dwell_q;
    target_d   = target_q;
    ho_req_d   = ho_req_q;
    attached_d = attached_q;
    ho_busy_d  = ho_busy_q;
    ho_count_d = ho_count_q;
    case (state_q)
      IDLE: begin
        if (cand_vld) begin
          cand_d   = cand_idx;
          ho_req_d = cand_oh;
          timer_d  = '0;
          state_d  = CONNECT;
        end
      end
      CONNECT: begin
        if (ack_hit) begin
          ho_req_d   = 3'b000;
          target_d   = cand_q;
          attached_d = 1'b1;
          dwell_d    = '0;
          state_d    = ATTACHED;
        end else if (timer_q == TMAX) begin
          ho_req_d = 3'b000;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ATTACHED: begin
        if (!serv_ok) begin
          target_d   = NONE;
          attached_d = 1'b0;
          dwell_d    = '0;
          state_d    = IDLE;
        end else if (ho_cond) begin
          cand_d = cand_idx;
          if (dwell_n >= DMAX) begin
            ho_req_d  = cand_oh;
            ho_busy_d = 1'b1;
            dwell_d   = '0;
            timer_d   = '0;
            state_d   = HANDOVER;
          end else begin
            dwell_d = dwell_n;
          end
        end else begin
          dwell_d = '0;
        end
      end
      HANDOVER: begin
        // Old link keeps serving; its loss is picked up back in ATTACHED
        if (ack_hit) begin
          target_d  = cand_q;
          ho_req_d  = 3'b000;
          ho_busy_d = 1'b0;
          if (ho_count_q != 8'hFF) ho_count_d = ho_count_q + 8'd1;
          state_d   = ATTACHED;
        end else if (timer_q == TMAX) begin
          ho_req_d  = 3'b000;
          ho_busy_d = 1'b0;
          state_d   = ATTACHED;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides everything including an open handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= 2'd0;
      timer_q    <= '0;
      dwell_q    <= '0;
      target_q   <= NONE;
      ho_req_q   <= 3'b000;
      attached_q <= 1'b0;
      ho_busy_q  <= 1'b0;
      ho_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      timer_q    <= timer_d;
      dwell_q    <= dwell_d;
      target_q   <= target_d;
      ho_req_q   <= ho_req_d;
      attached_q <= attached_d;
      ho_busy_q  <= ho_busy_d;
      ho_count_q <= ho_count_d;
    end
  end

  assign target   = target_q;
  assign ho_req   = ho_req_q;
  assign attached = attached_q;
  assign ho_busy  = ho_busy_q;
  assign ho_count = ho_count_q;

endmodule

// File: tb/tb_md_handover_ctrl.sv
// Directed-vector bench for md_handover_ctrl with a queue-based scoreboard.
// Stimulus drives on the falling edge and queues the output expected after the next rising edge.
// A monitor pops one entry per rising edge and compares the masked fields.
module tb_md_handover_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] bs_request;
    logic [1:0] sq1, sq2, sq3;
    logic [2:0] bs_ack;
    logic [1:0] target;
    logic [2:0] ho_req;
    logic       attached;
    logic       ho_busy;
    logic [7:0] ho_count;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] MT = 5'h01, MR = 5'h02, MA = 5'h04, MB = 5'h08, MC = 5'h10;
    localparam logic [4:0] ALL = 5'h1F;

    typedef struct {
        string      name;
        logic [4:0] mask;
        logic [1:0] target;
        logic [2:0] ho_req;
        logic       attached;
        logic       ho_busy;
        logic [7:0] ho_count;
    } exp_t;

    exp_t sb[$];

    md_handover_ctrl #(.MIN_SQ(1), .HYST(1), .DWELL(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bs_request (bs_request),
        .sq1        (sq1),
        .sq2        (sq2),
        .sq3        (sq3),
        .bs_ack     (bs_ack),
        .target     (target),
        .ho_req     (ho_req),
        .attached   (attached),
        .ho_busy    (ho_busy),
        .ho_count   (ho_count)
    );

    always #5 clk = ~clk;

    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                bad = 1'b0;
                if (e.mask[0] && target   !== e.target)   bad = 1'b1;
                if (e.mask[1] && ho_req   !== e.ho_req)   bad = 1'b1;
                if (e.mask[2] && attached !== e.attached) bad = 1'b1;
                if (e.mask[3] && ho_busy  !== e.ho_busy)  bad = 1'b1;
                if (e.mask[4] && ho_count !== e.ho_count) bad = 1'b1;
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got target=%0d ho_req=%b attached=%b ho_busy=%b ho_count=%0d, expected target=%0d ho_req=%b attached=%b ho_busy=%b ho_count=%0d (field mask %b)",
                             e.name, target, ho_req, attached, ho_busy, ho_count,
                             e.target, e.ho_req, e.attached, e.ho_busy, e.ho_count, e.mask);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input string nm, input logic [4:0] m, input logic [1:0] t,
                        input logic [2:0] r, input logic a, input logic b, input logic [7:0] c);
        exp_t e;
        if (m != 5'h00) begin
            e.name = nm; e.mask = m; e.target = t; e.ho_req = r;
            e.attached = a; e.ho_busy = b; e.ho_count = c;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic [2:0] req, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] s3, input logic [2:0] ack);
        reset = rst; bs_request = req; sq1 = s1; sq2 = s2; sq3 = s3; bs_ack = ack;
    endtask

    initial begin
        drive(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
        @(negedge clk);

        tick("reset", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);

        drive(1'b0, 3'b011, 2'd2, 2'd3, 2'd0, 3'b000);
        tick("attach_req", ALL, 2'd3, 3'b010, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd2, 2'd3, 2'd0, 3'b001);
        tick("attach_foreign_ack", ALL, 2'd3, 3'b010, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd2, 2'd3, 2'd0, 3'b010);
        tick("attach_ack", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd2, 2'd3, 2'd0, 3'b000);
        tick("attach_stable", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd0);
        checks++;
        if (target !== 2'd1 || attached !== 1'b1) begin
            errors++;
            $display("FAIL direct_attach: target=%0d attached=%b", target, attached);
        end

        drive(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
        tick("reset2", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);

        drive(1'b0, 3'b101, 2'd2, 2'd0, 2'd2, 3'b000);
        tick("tie_req", ALL, 2'd3, 3'b001, 1'b0, 1'b0, 8'd0);
        checks++;
        if (ho_req !== 3'b001) begin
            errors++;
            $display("FAIL direct_tie: ho_req=%b", ho_req);
        end
        for (int i = 0; i < 7; i++) tick("tie_wait", ALL, 2'd3, 3'b001, 1'b0, 1'b0, 8'd0);
        tick("connect_timeout", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);
        tick("re_request", ALL, 2'd3, 3'b001, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b101, 2'd2, 2'd0, 2'd2, 3'b001);
        tick("attach_bs1", ALL, 2'd0, 3'b000, 1'b1, 1'b0, 8'd0);

        drive(1'b0, 3'b001, 2'd1, 2'd0, 2'd0, 3'b000);
        tick("serve_bs1", ALL, 2'd0, 3'b000, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd1, 2'd3, 2'd0, 3'b000);
        for (int i = 0; i < 3; i++) tick("dwell_pending", ALL, 2'd0, 3'b000, 1'b1, 1'b0, 8'd0);
        tick("ho_issue", ALL, 2'd0, 3'b010, 1'b1, 1'b1, 8'd0);
        tick("mbb_hold", ALL, 2'd0, 3'b010, 1'b1, 1'b1, 8'd0);
        drive(1'b0, 3'b011, 2'd1, 2'd3, 2'd0, 3'b010);
        tick("ho_ack", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        checks++;
        if (ho_count !== 8'd1) begin
            errors++;
            $display("FAIL direct_ho_count: ho_count=%0d", ho_count);
        end

        drive(1'b0, 3'b011, 2'd2, 2'd2, 2'd0, 3'b000);
        for (int i = 0; i < 5; i++) tick("hyst_equal", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        drive(1'b0, 3'b011, 2'd3, 2'd2, 2'd0, 3'b000);
        for (int i = 0; i < 3; i++) tick("dwell_run_a", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        drive(1'b0, 3'b011, 2'd2, 2'd2, 2'd0, 3'b000);
        tick("dwell_break", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        drive(1'b0, 3'b011, 2'd3, 2'd2, 2'd0, 3'b000);
        for (int i = 0; i < 3; i++) tick("dwell_run_b", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        tick("dwell_fourth", ALL, 2'd1, 3'b001, 1'b1, 1'b1, 8'd1);
        drive(1'b0, 3'b011, 2'd2, 2'd2, 2'd0, 3'b000);
        for (int i = 0; i < 7; i++) tick("ho_wait", ALL, 2'd1, 3'b001, 1'b1, 1'b1, 8'd1);
        tick("ho_timeout", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);
        tick("ho_timeout_settled", ALL, 2'd1, 3'b000, 1'b1, 1'b0, 8'd1);

        drive(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
        tick("reset3", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);

        drive(1'b0, 3'b100, 2'd0, 2'd0, 2'd3, 3'b000);
        tick("bs3_req", ALL, 2'd3, 3'b100, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b100, 2'd0, 2'd0, 2'd3, 3'b100);
        tick("bs3_attach", ALL, 2'd2, 3'b000, 1'b1, 1'b0, 8'd0);
        drive(1'b0, 3'b001, 2'd1, 2'd0, 2'd3, 3'b000);
        tick("link_loss", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (target !== 2'd3 || attached !== 1'b0) begin
            errors++;
            $display("FAIL direct_link_loss: target=%0d attached=%b", target, attached);
        end
        tick("loss_rerequest", ALL, 2'd3, 3'b001, 1'b0, 1'b0, 8'd0);

        drive(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
        tick("reset4", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);

        drive(1'b0, 3'b010, 2'd0, 2'd0, 2'd0, 3'b000);
        tick("min_sq", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd1, 2'd0, 2'd0, 3'b000);
        tick("sat_req", ALL, 2'd3, 3'b001, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 3'b011, 2'd1, 2'd0, 2'd0, 3'b001);
        tick("sat_attach", ALL, 2'd0, 3'b000, 1'b1, 1'b0, 8'd0);

        for (int k = 1; k <= 256; k++) begin
            if (k % 2 == 1) begin
                drive(1'b0, 3'b011, 2'd1, 2'd3, 2'd0, 3'b000);
                for (int i = 0; i < 4; i++) tick("", 5'h00, 2'd0, 3'b000, 1'b0, 1'b0, 8'd0);
                drive(1'b0, 3'b011, 2'd1, 2'd3, 2'd0, 3'b010);
                tick("sat_count", MT | MC, 2'd1, 3'b000, 1'b0, 1'b0, (k > 255) ? 8'd255 : 8'(k));
            end else begin
                drive(1'b0, 3'b011, 2'd3, 2'd1, 2'd0, 3'b000);
                for (int i = 0; i < 4; i++) tick("", 5'h00, 2'd0, 3'b000, 1'b0, 1'b0, 8'd0);
                drive(1'b0, 3'b011, 2'd3, 2'd1, 2'd0, 3'b001);
                tick("sat_count", MT | MC, 2'd0, 3'b000, 1'b0, 1'b0, (k > 255) ? 8'd255 : 8'(k));
            end
        end
        checks++;
        if (ho_count !== 8'd255) begin
            errors++;
            $display("FAIL direct_saturation: ho_count=%0d", ho_count);
        end

        drive(1'b0, 3'b101, 2'd1, 2'd0, 2'd3, 3'b000);
        for (int i = 0; i < 3; i++) tick("", 5'h00, 2'd0, 3'b000, 1'b0, 1'b0, 8'd0);
        tick("ho_to_bs3", ALL, 2'd0, 3'b100, 1'b1, 1'b1, 8'd255);
        drive(1'b1, 3'b101, 2'd1, 2'd0, 2'd3, 3'b000);
        tick("reset_mid_ho", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);
        checks++;
        if (ho_req !== 3'b000 || target !== 2'd3 || ho_count !== 8'd0) begin
            errors++;
            $display("FAIL direct_reset_mid_ho: ho_req=%b target=%0d ho_count=%0d", ho_req, target, ho_count);
        end
        drive(1'b0, 3'b000, 2'd0, 2'd0, 2'd0, 3'b000);
        tick("idle_after_reset", ALL, 2'd3, 3'b000, 1'b0, 1'b0, 8'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
